multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle successor to the single-cycle MIPS control unit. Sequences each instruction (addu, subu, ori, lw, sw, beq, lui, jal, jr, sltu) through FETCH/DECODE/EXEC/MEM/WB states. Handshakes with instruction and data memories that may stall, and keeps a retired-instruction counter. Sits between the IR and the multi-cycle datapath (PC, GRF, ALU, EXT, DM, muxes M1–M3).

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; valid from DECODE onward
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory completes access this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- IRWr  out  1  latch instruction register
- PCWr  out  1  update PC with NPC result
- NPCOp  out  3  000 PC+4, 001 beq, 010 jal, 011 jr
- M1Sel  out  2  GRF write address: 00 rt, 01 rd, 10 $31
- M2Sel  out  2  GRF write data: 00 ALU, 01 DM, 10 PC+4
- M3Sel  out  1  ALU B: 0 GRF rt, 1 EXT
- RFWr  out  1  GRF write enable
- EXTOp  out  2  00 sign, 01 zero, 10 lui
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 sltu
- DMWr  out  1  DM write enable
- instr_done  out  1  one-cycle pulse, equal to PCWr
- retired  out  CNT_W  count of completed instructions
- illegal  out  1  sticky trap flag (only with macro)

## Operation
- State register holds FETCH, DECODE, EXEC, MEM, WB, plus TRAP when the macro is defined.
- All control outputs are combinational, derived from state and op/funct. The PC changes only once per instruction, in its final state, via a single PCWr pulse.
- FETCH: imem_req=1. On imem_ready: IRWr=1, go to DECODE. Otherwise stay.
- DECODE:
  - jal: RFWr=1, M1Sel=10, M2Sel=10, PCWr=1, NPCOp=010, go to FETCH.
  - jr: PCWr=1, NPCOp=011, go to FETCH.
  - Any other legal instruction: go to EXEC.
- EXEC: drives ALUOp, M3Sel and EXTOp per instruction.
  - beq: ALUOp=001, PCWr=1, NPCOp=001, go to FETCH. The NPC unit resolves taken/not-taken from ALU zero.
  - lw/sw: ALUOp=000, M3Sel=1, EXTOp=00, go to MEM.
  - Others: go to WB.
- MEM: dmem_req=1, and DMWr=1 for sw while in MEM. On dmem_ready:
  - sw: PCWr=1, go to FETCH.
  - lw: go to WB.
- WB: RFWr=1, PCWr=1, NPCOp=000, go to FETCH. Encodings:
  - R-type: M1Sel=01, M2Sel=00, M3Sel=0.
  - ori/lui: M1Sel=00, M2Sel=00, M3Sel=1, EXTOp=01/10 respectively, ALUOp=010 (ori) or 000 (lui).
  - lw: M2Sel=01, M1Sel=00.
- retired increments by 1 on every PCWr and wraps from 2^CNT_W−1 to 0.
- imem_ready is ignored outside FETCH. dmem_ready is ignored outside MEM.

## Timing
- Reset (asynchronous) puts the FSM in FETCH and clears retired and illegal.
- While reset is high, imem_req, dmem_req, IRWr, PCWr, RFWr, DMWr are forced to 0. All other outputs are 0.
- Latencies with zero-wait memory (ready in the same cycle as req):
  - jal/jr: 2 cycles.
  - beq: 3 cycles.
  - R-type, ori, lui: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle with ready low while req is high adds exactly one cycle.
- Reset asserted during MEM aborts the access. No DMWr or RFWr occurs after reset, and retired does not count the aborted instruction.
- At most one PCWr pulse per instruction. instr_done and retired update are coincident with it, and the new retired value is visible the cycle after the pulse.

## Configuration
- MCTRL_ILLEGAL_TRAP_EN defined:
  - An unrecognised op/funct in DECODE sets illegal=1 and moves to TRAP.
  - TRAP asserts no requests or writes and is left only by reset.
- Macro undefined:
  - An unrecognised instruction is a NOP: DECODE issues PCWr=1, NPCOp=000, and returns to FETCH (2 cycles, counted as retired).
  - illegal is tied to 0.

## Structure
- Package mctrl_pkg holds:
  - State encoding.
  - Opcode/funct constants.
  - NPCOp, M1Sel, M2Sel, EXTOp, ALUOp encodings.
- Sub-module mctrl_decode: purely combinational op/funct → one-hot instruction class plus a legal flag. The top module holds the FSM, output logic and counter.

## Test plan
- addu with imem_ready=dmem_ready=1 → IRWr in cycle 1; RFWr=1, M1Sel=01, PCWr=1 in cycle 4; retired goes 0→1.
- lw with dmem_ready held low for 3 cycles in MEM → dmem_req high 4 cycles; WB with M2Sel=01 at cycle 8; exactly one PCWr.
- beq → PCWr with NPCOp=001 in EXEC (cycle 3); RFWr and DMWr never asserted.
- jal then jr → each completes in 2 cycles; jal has RFWr=1, M1Sel=10, M2Sel=10; jr has NPCOp=011.
- sw, with reset asserted in MEM after 1 stall → DMWr drops to 0 asynchronously; after release FSM is in FETCH, retired=0.
- op=6'b111111 with macro → illegal=1, FSM in TRAP, no imem_req until reset. Without macro → NOP, retired increments.

Source files
------------

// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared encodings for the multi-cycle MIPS control unit.
//   - FSM state encoding (S_TRAP only exists when MCTRL_ILLEGAL_TRAP_EN is defined)
//   - opcode / funct constants for the supported instruction subset
//   - NPCOp, M1Sel, M2Sel, EXTOp, ALUOp encodings
//   - instr_cls_t: one-hot instruction class produced by mctrl_decode
package mctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef MCTRL_ILLEGAL_TRAP_EN
    , S_TRAP = 3'd5
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] NPC_PC4  = 3'b000;
  localparam logic [2:0] NPC_BEQ  = 3'b001;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JR   = 3'b011;

  localparam logic [1:0] M1_RT    = 2'b00;
  localparam logic [1:0] M1_RD    = 2'b01;
  localparam logic [1:0] M1_RA    = 2'b10;

  localparam logic [1:0] M2_ALU   = 2'b00;
  localparam logic [1:0] M2_DM    = 2'b01;
  localparam logic [1:0] M2_PC4   = 2'b10;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;

  typedef struct packed {
    logic addu;
    logic subu;
    logic sltu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic jal;
    logic jr;
  } instr_cls_t;

  // ALU operation an instruction class needs while its operands are live.
  function automatic logic [2:0] alu_op_of(input instr_cls_t c);
    logic [2:0] r;
    r = ALU_ADD;
    if (c.subu || c.beq) r = ALU_SUB;
    if (c.sltu)          r = ALU_SLTU;
    if (c.ori)           r = ALU_OR;
    return r;
  endfunction

endpackage

// File: rtl/mctrl_decode.sv
// mctrl_decode: purely combinational instruction classifier.
// Ports:
//   op, funct  in   IR[31:26] / IR[5:0]
//   cls        out  one-hot instruction class (all zero if unrecognised)
//   legal      out  1 when op/funct is one of the supported instructions
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output instr_cls_t cls,
  output logic       legal
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_SLTU: cls.sltu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls      = '0;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls     = '0;
    endcase
  end

  assign legal = |cls;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle MIPS control unit (FETCH/DECODE/EXEC/MEM/WB).
// Optional feature macro: MCTRL_ILLEGAL_TRAP_EN -- unrecognised instructions trap
// (sticky illegal flag, TRAP state left only by reset). Without it they retire as NOPs.
//
// state  | meaning
// FETCH  | imem_req high, wait for imem_ready, latch IR
// DECODE | classify; jal/jr (and NOPs) complete here
// EXEC   | ALU operands set up; beq completes here
// MEM    | data access, wait for dmem_ready; sw completes here
// WB     | register write-back, PC+4
// TRAP   | illegal instruction seen, idle until reset (macro only)
//
// Ports:
//   clk, reset            clock, async active-high reset
//   op, funct             IR fields, valid from DECODE onward
//   imem_ready/dmem_ready memory handshakes
//   imem_req/dmem_req     memory requests
//   IRWr PCWr NPCOp M1Sel M2Sel M3Sel RFWr EXTOp ALUOp DMWr  datapath controls
//   instr_done            equals PCWr
//   retired               count of completed instructions (wraps)
//   illegal               sticky trap flag (0 without macro)
module multicycle_controller
  import mctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWr,
  output logic             PCWr,
  output logic [2:0]       NPCOp,
  output logic [1:0]       M1Sel,
  output logic [1:0]       M2Sel,
  output logic             M3Sel,
  output logic             RFWr,
  output logic [1:0]       EXTOp,
  output logic [2:0]       ALUOp,
  output logic             DMWr,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  instr_cls_t       cls;
  logic             legal;

  logic             imem_req_c, dmem_req_c, ir_wr_c, pc_wr_c, rf_wr_c, dm_wr_c, m3_sel_c;
  logic [2:0]       npc_op_c, alu_op_c;
  logic [1:0]       m1_sel_c, m2_sel_c, ext_op_c;

`ifdef MCTRL_ILLEGAL_TRAP_EN
  logic             illegal_q, illegal_d;
`endif

  mctrl_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls),
    .legal (legal)
  );

  always_comb begin
    state_d    = state_q;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    ir_wr_c    = 1'b0;
    pc_wr_c    = 1'b0;
    rf_wr_c    = 1'b0;
    dm_wr_c    = 1'b0;
    npc_op_c   = NPC_PC4;
    m1_sel_c   = M1_RT;
    m2_sel_c   = M2_ALU;
    m3_sel_c   = 1'b0;
    ext_op_c   = EXT_SIGN;
    alu_op_c   = ALU_ADD;

    // Operand controls are held from EXEC through WB so the ALU result stays
    // stable for the address (MEM) and the write-back value (WB).
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_op_c = alu_op_of(cls);
      m3_sel_c = cls.ori | cls.lui | cls.lw | cls.sw;
      if (cls.ori) ext_op_c = EXT_ZERO;
      if (cls.lui) ext_op_c = EXT_LUI;
    end

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_wr_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls.jal) begin
          rf_wr_c  = 1'b1;
          m1_sel_c = M1_RA;
          m2_sel_c = M2_PC4;
          pc_wr_c  = 1'b1;
          npc_op_c = NPC_JAL;
          state_d  = S_FETCH;
        end else if (cls.jr) begin
          pc_wr_c  = 1'b1;
          npc_op_c = NPC_JR;
          state_d  = S_FETCH;
        end else if (legal) begin
          state_d  = S_EXEC;
        end else begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = S_TRAP;
`else
          pc_wr_c  = 1'b1;
          npc_op_c = NPC_PC4;
          state_d  = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (cls.beq) begin
          pc_wr_c  = 1'b1;
          npc_op_c = NPC_BEQ;
          state_d  = S_FETCH;
        end else if (cls.lw || cls.sw) begin
          state_d  = S_MEM;
        end else begin
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dm_wr_c    = cls.sw;
        if (dmem_ready) begin
          if (cls.sw) begin
            pc_wr_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_wr_c  = 1'b1;
        pc_wr_c  = 1'b1;
        npc_op_c = NPC_PC4;
        if (cls.addu || cls.subu || cls.sltu) m1_sel_c = M1_RD;
        if (cls.lw) m2_sel_c = M2_DM;
        state_d  = S_FETCH;
      end
`ifdef MCTRL_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase

    // Outputs are combinational, so reset must squash them directly; this is
    // what makes an in-flight sw stop writing the moment reset rises.
    if (reset) begin
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      ir_wr_c    = 1'b0;
      pc_wr_c    = 1'b0;
      rf_wr_c    = 1'b0;
      dm_wr_c    = 1'b0;
      npc_op_c   = NPC_PC4;
      m1_sel_c   = M1_RT;
      m2_sel_c   = M2_ALU;
      m3_sel_c   = 1'b0;
      ext_op_c   = EXT_SIGN;
      alu_op_c   = ALU_ADD;
    end

    retired_d = retired_q + {{(CNT_W-1){1'b0}}, pc_wr_c};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

`ifdef MCTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign imem_req   = imem_req_c;
  assign dmem_req   = dmem_req_c;
  assign IRWr       = ir_wr_c;
  assign PCWr       = pc_wr_c;
  assign NPCOp      = npc_op_c;
  assign M1Sel      = m1_sel_c;
  assign M2Sel      = m2_sel_c;
  assign M3Sel      = m3_sel_c;
  assign RFWr       = rf_wr_c;
  assign EXTOp      = ext_op_c;
  assign ALUOp      = alu_op_c;
  assign DMWr       = dm_wr_c;
  assign instr_done = pc_wr_c;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op, funct;
  logic             imem_ready, dmem_ready;
  logic             imem_req, dmem_req, IRWr, PCWr, M3Sel, RFWr, DMWr, instr_done, illegal;
  logic [2:0]       NPCOp, ALUOp;
  logic [1:0]       M1Sel, M2Sel, EXTOp;
  logic [CNT_W-1:0] retired;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWr(IRWr), .PCWr(PCWr),
    .NPCOp(NPCOp), .M1Sel(M1Sel), .M2Sel(M2Sel), .M3Sel(M3Sel), .RFWr(RFWr),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .DMWr(DMWr), .instr_done(instr_done),
    .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] npc;
    logic [1:0] m1, m2;
    logic [2:0] alu;
    logic       m3;
    logic [1:0] ext;
    logic [4:0] mask;   // [4]=M1Sel [3]=M2Sel [2]=ALUOp [1]=M3Sel [0]=EXTOp
    int         lat;    // IRWr cycle .. PCWr cycle inclusive
    int         dreq;   // cycles with dmem_req
    int         dmwr;   // cycles with DMWr
    int         rfwr;   // cycles with RFWr
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_retired = 0;
  int   dmem_stall_left = 0;
  bit   fetch_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Memory model: responds after posedge, stalls dmem while dmem_stall_left > 0.
  always @(posedge clk) begin
    #2;
    imem_ready = fetch_en;
    if (dmem_req && dmem_stall_left > 0) begin
      dmem_ready = 1'b0;
      dmem_stall_left--;
    end else begin
      dmem_ready = 1'b1;
    end
  end

  // Monitor / scoreboard: every PCWr pulse retires the oldest expected entry.
  int cyc = 0, dreq_c = 0, dmwr_c = 0, rfwr_c = 0;
  bit chk_next = 0;
  always @(negedge clk) begin
    if (reset) begin
      cyc = 0; dreq_c = 0; dmwr_c = 0; rfwr_c = 0; chk_next = 0;
    end else begin
      if (chk_next) begin
        chk("retired_after_pulse", retired, exp_retired);
        chk_next = 0;
      end
      if (IRWr) cyc = 1;
      else if (cyc > 0) cyc++;
      if (dmem_req) dreq_c++;
      if (DMWr) dmwr_c++;
      if (RFWr) rfwr_c++;
      if (!PCWr && instr_done) chk("instr_done_without_pcwr", instr_done, 0);
      if (PCWr) begin
        if (q.size() == 0) begin
          chk("unexpected_pcwr", PCWr, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, ":NPCOp"}, NPCOp, e.npc);
          chk({e.name, ":latency"}, cyc, e.lat);
          chk({e.name, ":dmem_req_cycles"}, dreq_c, e.dreq);
          chk({e.name, ":DMWr_cycles"}, dmwr_c, e.dmwr);
          chk({e.name, ":RFWr_cycles"}, rfwr_c, e.rfwr);
          chk({e.name, ":instr_done"}, instr_done, 1);
          chk({e.name, ":retired_at_pulse"}, retired, exp_retired);
          if (e.mask[4]) chk({e.name, ":M1Sel"}, M1Sel, e.m1);
          if (e.mask[3]) chk({e.name, ":M2Sel"}, M2Sel, e.m2);
          if (e.mask[2]) chk({e.name, ":ALUOp"}, ALUOp, e.alu);
          if (e.mask[1]) chk({e.name, ":M3Sel"}, M3Sel, e.m3);
          if (e.mask[0]) chk({e.name, ":EXTOp"}, EXTOp, e.ext);
          exp_retired++;
          chk_next = 1;
        end
        cyc = 0; dreq_c = 0; dmwr_c = 0; rfwr_c = 0;
      end
    end
  end

  task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f, input int dst,
                       input logic [2:0] npc, input logic [1:0] m1, input logic [1:0] m2,
                       input logic [2:0] alu, input logic m3, input logic [1:0] ext,
                       input logic [4:0] mask, input int lat, input int dreq,
                       input int dmwr, input int rfwr);
    exp_t e;
    e.name = nm; e.npc = npc; e.m1 = m1; e.m2 = m2; e.alu = alu; e.m3 = m3; e.ext = ext;
    e.mask = mask; e.lat = lat; e.dreq = dreq; e.dmwr = dmwr; e.rfwr = rfwr;
    @(posedge clk); #1;
    op = o; funct = f; dmem_stall_left = dst; fetch_en = 1;
    q.push_back(e);
    @(posedge clk); #1;
    fetch_en = 0;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      chk({nm, ":timeout_no_pcwr"}, 1, 0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; op = 6'h00; funct = 6'h00; imem_ready = 0; dmem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:imem_req", imem_req, 0);
    chk("rst:dmem_req", dmem_req, 0);
    chk("rst:IRWr", IRWr, 0);
    chk("rst:PCWr", PCWr, 0);
    chk("rst:RFWr", RFWr, 0);
    chk("rst:DMWr", DMWr, 0);
    chk("rst:NPCOp", NPCOp, 0);
    chk("rst:retired", retired, 0);
    chk("rst:illegal", illegal, 0);
    reset = 0;
    #1 chk("post_rst:imem_req_fetch", imem_req, 1);

    //     name    op         funct      dst npc     m1     m2     alu     m3    ext    mask      lat dreq dmwr rfwr
    issue("addu",  6'b000000, 6'b100001, 0, 3'b000, 2'b01, 2'b00, 3'b000, 1'b0, 2'b00, 5'b11110, 4, 0, 0, 1);
    issue("subu",  6'b000000, 6'b100011, 0, 3'b000, 2'b01, 2'b00, 3'b001, 1'b0, 2'b00, 5'b11110, 4, 0, 0, 1);
    issue("sltu",  6'b000000, 6'b101011, 0, 3'b000, 2'b01, 2'b00, 3'b011, 1'b0, 2'b00, 5'b11110, 4, 0, 0, 1);
    issue("ori",   6'b001101, 6'b000000, 0, 3'b000, 2'b00, 2'b00, 3'b010, 1'b1, 2'b01, 5'b11111, 4, 0, 0, 1);
    issue("lui",   6'b001111, 6'b000000, 0, 3'b000, 2'b00, 2'b00, 3'b000, 1'b1, 2'b10, 5'b11111, 4, 0, 0, 1);
    issue("lw",    6'b100011, 6'b000000, 0, 3'b000, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00, 5'b11000, 5, 1, 0, 1);
    issue("lw_s3", 6'b100011, 6'b000000, 3, 3'b000, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00, 5'b11000, 8, 4, 0, 1);
    issue("sw",    6'b101011, 6'b000000, 0, 3'b000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 5'b00000, 4, 1, 1, 0);
    issue("sw_s2", 6'b101011, 6'b000000, 2, 3'b000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 5'b00000, 6, 3, 3, 0);
    issue("beq",   6'b000100, 6'b000000, 0, 3'b001, 2'b00, 2'b00, 3'b001, 1'b0, 2'b00, 5'b00110, 3, 0, 0, 0);
    issue("jal",   6'b000011, 6'b000000, 0, 3'b010, 2'b10, 2'b10, 3'b000, 1'b0, 2'b00, 5'b11000, 2, 0, 0, 1);
    issue("jr",    6'b000000, 6'b001000, 0, 3'b011, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 5'b00000, 2, 0, 0, 0);
`ifndef MCTRL_ILLEGAL_TRAP_EN
    issue("nop_op3f",  6'b111111, 6'b000000, 0, 3'b000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 5'b00000, 2, 0, 0, 0);
    issue("nop_fn00",  6'b000000, 6'b000000, 0, 3'b000, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 5'b00000, 2, 0, 0, 0);
`endif
    @(posedge clk); #1;
    chk("retired_total", retired, exp_retired);

    // sw aborted by reset in MEM after one stall cycle
    op = 6'b101011; funct = 6'b000000; dmem_stall_left = 10; fetch_en = 1;
    @(posedge clk); #1; fetch_en = 0;                 // DECODE
    @(posedge clk); #1;                               // EXEC
    @(posedge clk); #1;                               // MEM, stall 1
    chk("abort:dmem_req_mem1", dmem_req, 1);
    @(posedge clk); #2;                               // MEM, after one stall
    chk("abort:DMWr_before_reset", DMWr, 1);
    reset = 1;
    exp_retired = 0;
    #1;
    chk("abort:DMWr_async_drop", DMWr, 0);
    chk("abort:dmem_req_drop", dmem_req, 0);
    chk("abort:RFWr", RFWr, 0);
    chk("abort:PCWr", PCWr, 0);
    @(posedge clk); #1;
    chk("abort:retired_cleared", retired, 0);
    dmem_stall_left = 0;
    reset = 0;
    #1;
    chk("abort:fetch_after_release", imem_req, 1);
    chk("abort:dmem_req_after_release", dmem_req, 0);
    issue("addu_after_abort", 6'b000000, 6'b100001, 0, 3'b000, 2'b01, 2'b00, 3'b000, 1'b0, 2'b00, 5'b11110, 4, 0, 0, 1);
    @(posedge clk); #1;
    chk("retired_after_abort", retired, 1);

`ifdef MCTRL_ILLEGAL_TRAP_EN
    @(posedge clk); #1;
    op = 6'b111111; funct = 6'b000000; fetch_en = 1;
    @(posedge clk); #1; fetch_en = 0;                 // DECODE
    @(posedge clk); #1;                               // TRAP
    chk("trap:illegal", illegal, 1);
    for (int i = 0; i < 4; i++) begin
      chk("trap:imem_req", imem_req, 0);
      chk("trap:PCWr", PCWr, 0);
      @(posedge clk); #1;
    end
    chk("trap:illegal_sticky", illegal, 1);
    chk("trap:retired_unchanged", retired, 1);
    reset = 1;
    exp_retired = 0;
    #1 chk("trap:illegal_cleared", illegal, 0);
    @(posedge clk); #1;
    reset = 0;
    #1 chk("trap:fetch_after_reset", imem_req, 1);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
